flex_deserializer: RTL and testbench
====================================

FLEX_DESERIALIZER -- requirements
Module: flex_deserializer

Interface
REQ-001 Parameter IN_WIDTH, default 8: input beat width in bits (>=1).
REQ-002 Parameter RATIO, default 8: input beats per output word (any integer 2..16; not restricted to powers of two).
REQ-003 Parameter LSB_FIRST, default 1: 1 = first beat lands in lane 0 (bits [IN_WIDTH-1:0]); 0 = first beat lands in lane RATIO-1.
REQ-004 clk  input  1  the only clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  the input beat is present.
REQ-007 in_ready  output  1  the block accepts a beat this cycle.
REQ-008 in_data  input  IN_WIDTH  the input beat.
REQ-009 in_last  input  1  the beat ends the current word (flush), qualified by in_valid.
REQ-010 out_valid  output  1  the output word is present.
REQ-011 out_ready  input  1  the downstream accepts the output word.
REQ-012 out_data  output  IN_WIDTH*RATIO  the assembled word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
REQ-013 out_keep  output  RATIO  bit k set = lane k holds a received beat.
REQ-014 out_last  output  1  the word was closed by in_last.

Function
REQ-015 A beat is accepted when in_valid && in_ready; an output word is taken when out_valid && out_ready.
REQ-016 State: an accumulator (data, lane count 0..RATIO-1, keep, pending flag) plus a one-entry output register (out_data, out_keep, out_last, out_valid).
REQ-017 in_ready = !pending; it is purely registered, with no combinational path from any input.
REQ-018 Lane placement: beat n (0-based) of a word goes to lane n when LSB_FIRST=1, and to lane RATIO-1-n when LSB_FIRST=0.
REQ-019 A word completes when an accepted beat is beat RATIO-1 or carries in_last=1.
REQ-020 slot_free = !out_valid || out_ready.
REQ-021 On completion with slot_free=1: next cycle the output register holds the word (out_valid=1), the accumulator clears, and pending stays 0. Latency is 1 cycle from the completing beat to out_valid.
REQ-022 On completion with slot_free=0: the accumulator holds the word and pending becomes 1.
REQ-023 While pending=1 and slot_free=1: the word moves to the output register and the accumulator clears, in the same cycle; in_ready is 1 in the following cycle.
REQ-024 Output register behaviour:
  - it holds stable while out_valid && !out_ready;
  - out_valid deasserts after a take unless a new word loads in the same cycle (back-to-back words, no bubble).
REQ-025 Lanes not filled in a flushed word are 0 and their out_keep bits are 0; a full word has out_keep all ones.
REQ-026 out_last=1 only for words closed by in_last, including when in_last arrives on beat RATIO-1.
REQ-027 There are no empty words: in_last is meaningful only on an accepted beat. in_valid without in_ready has no effect.
REQ-028 Sustained throughput is one beat per cycle while out_ready=1; in_ready never drops in that case.
REQ-029 The lane counter uses ceil(log2(RATIO)) bits and wraps explicitly to 0 at RATIO-1, not by natural overflow.

Reset
REQ-030 While rst=1 at a clock edge, the block clears:
  - out_valid, out_last, out_keep, out_data to 0;
  - lane count, keep, accumulator data and pending to 0.
REQ-031 in_ready is 1 from the first cycle after reset.
REQ-032 Reset mid-word or mid-stall discards the partial word, the pending word and the output word; none is ever emitted.

Verification (IN_WIDTH=8, RATIO=3 unless stated)
REQ-033 LSB_FIRST=1, out_ready=1, beats 0x11,0x22,0x33 on consecutive cycles -> one cycle after the 3rd beat: out_data=0x332211, out_keep=3'b111, out_last=0, out_valid high for 1 cycle.
REQ-034 Beats 0xAA, then 0xBB with in_last=1 -> out_data=0x00BBAA, out_keep=3'b011, out_last=1; the next word starts at lane 0.
REQ-035 out_ready=0, 6 beats 0x01..0x06:
  - out_data=0x030201 held stable; pending=1 and in_ready=0 after the 6th beat;
  - then out_ready=1 -> 0x030201 then 0x060504 on consecutive cycles, and in_ready=1 one cycle after the pending transfer.
REQ-036 LSB_FIRST=0:
  - 0x11,0x22,0x33 -> 0x112233;
  - then 0x44 with in_last -> out_data=0x440000, out_keep=3'b100, out_last=1.
REQ-037 Two beats, rst for 1 cycle, then 0x01,0x02,0x03 -> exactly one word 0x030201; no word is emitted from the pre-reset beats.
REQ-038 RATIO=5, 50 consecutive beats with out_ready=1 -> 10 words in order, in_ready constantly 1, and 1 cycle of latency per word.

Source files
------------

// File: rtl/flex_deserializer.sv
// Packs RATIO input beats (or fewer, closed by in_last) into one output word; 1 cycle beat-to-word latency.
// One word can wait in the accumulator behind a stalled output register; in_ready = !pending, fully registered.
module flex_deserializer #(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_WIDTH*RATIO-1:0]    out_data,
  output logic [RATIO-1:0]             out_keep,
  output logic                         out_last
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OW = IN_WIDTH * RATIO;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [OW-1:0]    r_acc_data;
  logic [RATIO-1:0] r_acc_keep;
  logic             r_acc_last;
  logic [CW-1:0]    r_cnt;
  logic             r_pending;
  logic [OW-1:0]    r_out_data;
  logic [RATIO-1:0] r_out_keep;
  logic             r_out_last;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_slot_free;
  logic             w_complete;
  logic [CW-1:0]    w_lane;
  logic [CW-1:0]    w_cnt_nxt;
  logic [OW-1:0]    w_word_data;
  logic [RATIO-1:0] w_word_keep;

  assign w_accept    = in_valid && !r_pending;
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_complete  = w_accept && ((r_cnt == LAST_LANE) || in_last);
  assign w_cnt_nxt   = (r_cnt == LAST_LANE) ? '0 : r_cnt + 1'b1;

  // Accumulator contents with the current beat merged into its lane.
  always_comb begin
    w_lane      = (LSB_FIRST != 0) ? r_cnt : LAST_LANE - r_cnt;
    w_word_data = r_acc_data;
    w_word_keep = r_acc_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (w_lane == CW'(k)) begin
        w_word_data[k*IN_WIDTH +: IN_WIDTH] = in_data;
        w_word_keep[k]                      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_data  <= '0;
      r_acc_keep  <= '0;
      r_acc_last  <= 1'b0;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_pending) begin
        if (w_slot_free) begin
          r_out_data  <= r_acc_data;
          r_out_keep  <= r_acc_keep;
          r_out_last  <= r_acc_last;
          r_out_valid <= 1'b1;
          r_acc_data  <= '0;
          r_acc_keep  <= '0;
          r_acc_last  <= 1'b0;
          r_pending   <= 1'b0;
        end
      end else if (w_complete) begin
        r_cnt <= '0;
        if (w_slot_free) begin
          r_out_data  <= w_word_data;
          r_out_keep  <= w_word_keep;
          r_out_last  <= in_last;
          r_out_valid <= 1'b1;
          r_acc_data  <= '0;
          r_acc_keep  <= '0;
          r_acc_last  <= 1'b0;
        end else begin
          // Output still occupied: park the finished word and stall the input.
          r_acc_data <= w_word_data;
          r_acc_keep <= w_word_keep;
          r_acc_last <= in_last;
          r_pending  <= 1'b1;
        end
      end else if (w_accept) begin
        r_acc_data <= w_word_data;
        r_acc_keep <= w_word_keep;
        r_cnt      <= w_cnt_nxt;
      end
    end
  end

  assign in_ready  = !r_pending;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_flex_deserializer.sv
// Drives three deserializer configurations with shared stimulus; a word-level model checks every cycle.
module tb_flex_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic        a_ir, a_ov, a_ol, b_ir, b_ov, b_ol, c_ir, c_ov, c_ol;
  logic [23:0] a_od, b_od;
  logic [39:0] c_od;
  logic [2:0]  a_ok, b_ok;
  logic [4:0]  c_ok;

  flex_deserializer #(.IN_WIDTH(8), .RATIO(3), .LSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
    .in_last(in_last), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_keep(a_ok), .out_last(a_ol));
  flex_deserializer #(.IN_WIDTH(8), .RATIO(3), .LSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
    .in_last(in_last), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_keep(b_ok), .out_last(b_ol));
  flex_deserializer #(.IN_WIDTH(8), .RATIO(5), .LSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data),
    .in_last(in_last), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .out_keep(c_ok), .out_last(c_ol));

  logic [39:0] act_d[3];
  logic [4:0]  act_k[3];
  logic        act_v[3], act_l[3], act_r[3];
  assign act_d[0] = {16'b0, a_od};  assign act_d[1] = {16'b0, b_od};  assign act_d[2] = c_od;
  assign act_k[0] = {2'b0, a_ok};   assign act_k[1] = {2'b0, b_ok};   assign act_k[2] = c_ok;
  assign act_v[0] = a_ov;  assign act_v[1] = b_ov;  assign act_v[2] = c_ov;
  assign act_l[0] = a_ol;  assign act_l[1] = b_ol;  assign act_l[2] = c_ol;
  assign act_r[0] = a_ir;  assign act_r[1] = b_ir;  assign act_r[2] = c_ir;

  int checks = 0;
  int failures = 0;

  // Model: up to two finished words held inside the block (output slot + parked word).
  int          RAT[3] = '{3, 3, 5};
  int          LSB[3] = '{1, 0, 1};
  logic [39:0] bd[3][2];
  logic [4:0]  bk[3][2];
  bit          bl[3][2];
  int          m_n[3];
  logic [39:0] pd[3];
  logic [4:0]  pk[3];
  int          pb[3];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_adv(input bit v, input logic [7:0] d, input bit l, input bit o, input bit r);
    for (int i = 0; i < 3; i++) begin
      bit acc, take;
      int lane;
      if (r) begin
        m_n[i] = 0; pd[i] = '0; pk[i] = '0; pb[i] = 0;
      end else begin
        acc  = v && (m_n[i] < 2);
        take = o && (m_n[i] > 0);
        if (take) begin
          bd[i][0] = bd[i][1]; bk[i][0] = bk[i][1]; bl[i][0] = bl[i][1];
          m_n[i]--;
        end
        if (acc) begin
          lane = (LSB[i] != 0) ? pb[i] : RAT[i] - 1 - pb[i];
          pd[i][lane*8 +: 8] = d;
          pk[i][lane] = 1'b1;
          pb[i]++;
          if (pb[i] == RAT[i] || l) begin
            bd[i][m_n[i]] = pd[i]; bk[i][m_n[i]] = pk[i]; bl[i][m_n[i]] = l;
            m_n[i]++;
            pd[i] = '0; pk[i] = '0; pb[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic model_chk();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d out_valid", i), 40'(act_v[i]), 40'(m_n[i] > 0));
      chk($sformatf("dut%0d in_ready", i), 40'(act_r[i]), 40'(m_n[i] < 2));
      if (m_n[i] > 0) begin
        chk($sformatf("dut%0d out_data", i), act_d[i], bd[i][0]);
        chk($sformatf("dut%0d out_keep", i), 40'(act_k[i]), 40'(bk[i][0]));
        chk($sformatf("dut%0d out_last", i), 40'(act_l[i]), 40'(bl[i][0]));
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit o, input bit r);
    in_valid = v; in_data = d; in_last = l; out_ready = o; rst = r;
    model_adv(v, d, l, o, r);
    @(posedge clk);
    #1;
    model_chk();
  endtask

  typedef struct {
    bit v; logic [7:0] d; bit l; bit o;
    bit ev; logic [23:0] ed; logic [2:0] ek; bit el; bit er;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int words;
    logic [39:0] w;
    int thr;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    // Configuration A (RATIO=3, LSB first): full word, flush, back-to-back, stall and release.
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 24'h332211, 3'b111, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 24'h00BBAA, 3'b011, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 24'h0000CC, 3'b001, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 24'h030201, 3'b111, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 24'h030201, 3'b111, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 24'h030201, 3'b111, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 24'h030201, 3'b111, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 24'h030201, 3'b111, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 24'h060504, 3'b111, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 24'h009988, 3'b011, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 24'h0,      3'b000, 1'b0, 1'b1};

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset dut%0d data", i), act_d[i], 40'h0);
      chk($sformatf("reset dut%0d keep", i), 40'(act_k[i]), 40'h0);
      chk($sformatf("reset dut%0d last", i), 40'(act_l[i]), 40'h0);
      chk($sformatf("reset dut%0d in_ready", i), 40'(act_r[i]), 40'h1);
    end

    for (int j = 0; j < 19; j++) begin
      step(tbl[j].v, tbl[j].d, tbl[j].l, tbl[j].o, 1'b0);
      chk($sformatf("vec%0d out_valid", j), 40'(a_ov), 40'(tbl[j].ev));
      chk($sformatf("vec%0d in_ready", j), 40'(a_ir), 40'(tbl[j].er));
      if (tbl[j].ev) begin
        chk($sformatf("vec%0d out_data", j), 40'(a_od), 40'(tbl[j].ed));
        chk($sformatf("vec%0d out_keep", j), 40'(a_ok), 40'(tbl[j].ek));
        chk($sformatf("vec%0d out_last", j), 40'(a_ol), 40'(tbl[j].el));
      end
    end

    // MSB-first lane placement and flush.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    chk("msb full valid", 40'(b_ov), 40'h1);
    chk("msb full data", 40'(b_od), 40'h112233);
    step(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
    chk("msb flush data", 40'(b_od), 40'h440000);
    chk("msb flush keep", 40'(b_ok), 40'h4);
    chk("msb flush last", 40'(b_ol), 40'h1);

    // Reset in the middle of a word discards it.
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    words = 0;
    for (int j = 0; j < 6; j++) begin
      step(j < 3, 8'(j + 1), 1'b0, 1'b1, 1'b0);
      if (a_ov) begin
        words++;
        chk("post-reset word", 40'(a_od), 40'h030201);
      end
    end
    chk("post-reset word count", 40'(words), 40'h1);

    // RATIO=5 streaming: one beat per cycle, word one cycle after its fifth beat.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int bt = 0; bt < 50; bt++) begin
      step(1'b1, 8'(bt + 1), 1'b0, 1'b1, 1'b0);
      chk($sformatf("stream in_ready beat%0d", bt), 40'(c_ir), 40'h1);
      if (bt % 5 == 4) begin
        w = '0;
        for (int k = 0; k < 5; k++) w[k*8 +: 8] = 8'(bt - 4 + k + 1);
        chk($sformatf("stream word%0d valid", bt / 5), 40'(c_ov), 40'h1);
        chk($sformatf("stream word%0d data", bt / 5), c_od, w);
        chk($sformatf("stream word%0d keep", bt / 5), 40'(c_ok), 40'h1F);
      end else begin
        chk($sformatf("stream idle beat%0d", bt), 40'(c_ov), 40'h0);
      end
    end

    // Random traffic with varying downstream pressure and occasional resets.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      thr = (n / 500) % 3 + 1;
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) < thr, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
